trolley_system_key_ctrl: RTL and testbench

Avalon-MM slave key controller for the trolley system push-buttons. Synchronises and debounces WIDTH active-low keys, captures press/release events into per-key pending bits, and raises one masked level interrupt. A pop-on-read EVENT register hands the CPU one pending key per read through a round-robin arbiter, so no key starves.

---
 rtl/trolley_system_key_ctrl_pkg.sv | 31 +++
 rtl/trolley_system_key_ctrl_if.sv | 25 ++
 rtl/trolley_system_key_ctrl_key_debounce.sv | 46 ++++
 rtl/trolley_system_key_ctrl.sv | 143 ++++++++++++++
 tb/tb_trolley_system_key_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trolley_system_key_ctrl_pkg.sv
// Trolley key controller: shared constants.
// Register map, CTRL bits and EVENT word layout.
package trolley_key_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_CTRL  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_EVENT = 3'd4;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_REL_EN  = 1;

  localparam int EV_VALID  = 31;
  localparam int EV_LEVEL  = 8;
  localparam int EV_ID_LSB = 0;

  function automatic logic [31:0] event_word(
    input logic       valid,
    input logic       level,
    input logic [3:0] id
  );
    logic [31:0] w;
    w = '0;
    w[EV_VALID] = valid;
    w[EV_LEVEL] = level;
    w[EV_ID_LSB +: 4] = id;
    return w;
  endfunction

endpackage

// File: rtl/trolley_system_key_ctrl_if.sv
// Trolley key controller: Avalon-MM slave bus bundle.
// Carries the register port plus the interrupt line.
interface trolley_system_key_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n,
    output write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n,
    input  write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/trolley_system_key_ctrl_key_debounce.sv
// Trolley key controller: per-key sync + debounce.
// Emits the accepted level and one-cycle rise/fall pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic             s0;
  logic             s1;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // sync the raw key, then accept a level once it holds long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s0       <= ~key_n;
      s1       <= s0;
      stable_q <= stable;
      if (s1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;

endmodule

// File: rtl/trolley_system_key_ctrl.sv
// Trolley key controller top: debounced keys, pending
// events, masked irq and a round-robin pop-on-read EVENT.
module trolley_system_key_ctrl
  import trolley_key_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  trolley_system_key_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]     key_n
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] grant_oh;
  logic [1:0]       ctrl;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] next_ptr;
  logic             hit;
  logic             rd;
  logic             wr;
  logic             pop;
  logic [31:0]      rd_next;
  logic [31:0]      readdata;
  logic             irq;
  logic             unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .key_n  (key_n[gi]),
        .stable (stable[gi]),
        .rise   (rise[gi]),
        .fall   (fall[gi])
      );
    end
  endgenerate

  assign rd   = bus.chipselect & ~bus.read_n;
  assign wr   = bus.chipselect & ~bus.write_n;
  assign cand = pending & irq_mask;

  // first candidate at or above rr_ptr, wrapping mod WIDTH
  always_comb begin
    logic [PTR_W:0] sum;
    hit   = 1'b0;
    grant = '0;
    sum   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(WIDTH)) begin
        sum = sum - (PTR_W+1)'(WIDTH);
      end
      if (!hit && cand[sum[PTR_W-1:0]]) begin
        hit   = 1'b1;
        grant = sum[PTR_W-1:0];
      end
    end
  end

  assign grant_oh = WIDTH'(1) << grant;
  assign next_ptr = (grant == PTR_W'(WIDTH - 1)) ?
                    '0 : grant + 1'b1;
  assign pop      = rd & (bus.address == ADDR_EVENT) & hit;

  assign set_v = rise |
                 (fall & {WIDTH{ctrl[CTRL_REL_EN]}});

  // W1C and pop clears; a same-cycle set wins below
  always_comb begin
    clr_v = '0;
    if (wr && bus.address == ADDR_EDGE) begin
      clr_v = bus.writedata[WIDTH-1:0];
    end
    if (pop) begin
      clr_v = clr_v | grant_oh;
    end
  end

  // read mux
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:  rd_next = 32'(stable);
      ADDR_CTRL:  rd_next = 32'(ctrl);
      ADDR_MASK:  rd_next = 32'(irq_mask);
      ADDR_EDGE:  rd_next = 32'(pending);
      ADDR_EVENT: rd_next = hit ?
        event_word(1'b1, stable[grant], 4'(grant)) : '0;
      default:    rd_next = '0;
    endcase
  end

  // register state, pending bits, arbiter pointer, irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      ctrl     <= '0;
      irq_mask <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (rd) begin
        readdata <= rd_next;
      end
      if (wr && bus.address == ADDR_CTRL) begin
        ctrl <= bus.writedata[1:0];
      end
      if (wr && bus.address == ADDR_MASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      pending <= (pending & ~clr_v) | set_v;
      if (pop) begin
        rr_ptr <= next_ptr;
      end
      irq <= ctrl[CTRL_IRQ_EN] & (|cand);
    end
  end

  assign bus.readdata = readdata;
  assign bus.irq      = irq;
  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_trolley_system_key_ctrl.sv
// Bench for trolley_system_key_ctrl: directed scenarios
// plus random traffic against a behavioural model.
module tb_trolley_system_key_ctrl;

  localparam int W   = 4;
  localparam int DEB = 4;
  localparam int CW  = 16;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key_n;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  trolley_system_key_ctrl_if bus();

  trolley_system_key_ctrl #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .key_n  (key_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // behavioural model
  logic [W-1:0] m_stable, m_rise, m_fall;
  logic [W-1:0] m_pend, m_mask;
  logic [1:0]   m_ctrl;
  int           m_rr;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [W-1:0] hist[$];

  task automatic model_reset();
    m_stable = '0; m_rise = '0; m_fall = '0;
    m_pend = '0; m_mask = '0; m_ctrl = '0;
    m_rr = 0; m_irq = 0; m_rd = '0;
    hist = {};
    repeat (DEB + 1) hist.push_back('0);
  endtask

  task automatic model_step();
    bit rd, wr, hit, same;
    logic [2:0] a;
    logic [31:0] d;
    logic [W-1:0] cand, clr, nst, setv;
    int g, j;
    rd = bus.chipselect && !bus.read_n;
    wr = bus.chipselect && !bus.write_n;
    a = bus.address;
    d = bus.writedata;
    cand = m_pend & m_mask;
    hit = 0; g = 0;
    for (int k = 0; k < W; k++) begin
      j = (m_rr + k) % W;
      if (!hit && cand[j]) begin hit = 1; g = j; end
    end
    m_irq = m_ctrl[0] && (cand != 0);
    clr = '0;
    if (rd) begin
      case (a)
        3'd0: m_rd = 32'(m_stable);
        3'd1: m_rd = 32'(m_ctrl);
        3'd2: m_rd = 32'(m_mask);
        3'd3: m_rd = 32'(m_pend);
        3'd4: m_rd = hit ? {1'b1, 22'b0, m_stable[g],
                            4'b0, 4'(g)} : 32'h0;
        default: m_rd = 32'h0;
      endcase
    end
    if (rd && a == 3'd4 && hit) begin
      clr[g] = 1'b1;
      m_rr = (g + 1) % W;
    end
    if (wr && a == 3'd3) clr = clr | d[W-1:0];
    setv = m_rise | (m_fall & {W{m_ctrl[1]}});
    m_pend = (m_pend & ~clr) | setv;
    if (wr && a == 3'd1) m_ctrl = d[1:0];
    if (wr && a == 3'd2) m_mask = d[W-1:0];
    nst = m_stable;
    for (int i = 0; i < W; i++) begin
      same = 1;
      for (int w = 1; w < DEB; w++)
        if (hist[w][i] != hist[0][i]) same = 0;
      if (same && hist[0][i] != m_stable[i])
        nst[i] = hist[0][i];
    end
    m_rise = nst & ~m_stable;
    m_fall = ~nst & m_stable;
    m_stable = nst;
    hist.push_back(~key_n);
    void'(hist.pop_front());
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (mon_en) chk("irq_model", 32'(bus.irq), 32'(m_irq));
  end

  // bus tasks: entered and left on a falling edge
  task automatic rd(input logic [2:0] a,
                    output logic [31:0] d);
    bus.chipselect = 1; bus.read_n = 0; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 0; bus.read_n = 1;
    chk($sformatf("rd_model_a%0d", a), d, m_rd);
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] v);
    bus.chipselect = 1; bus.write_n = 0;
    bus.address = a; bus.writedata = v;
    @(negedge clk);
    bus.chipselect = 0; bus.write_n = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    key_n = '1;
    idle(10);
    wr(3'd3, 32'hF);
  endtask

  logic [31:0] d;
  int r;

  initial begin
    assert (2 ** CW > DEB)
      else $fatal(1, "FAIL cnt_w: counter too narrow");
    reset_n = 0;
    key_n = '1;
    bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1;
    bus.address = '0; bus.writedata = '0;
    idle(3);
    reset_n = 1;
    idle(1);

    chk("reset_irq", 32'(bus.irq), 32'h0);
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      chk($sformatf("reset_rd_a%0d", a), d, 32'h0);
    end

    // debounce with bounce on key 1
    key_n[1] = 0; idle(1);
    key_n[1] = 1; idle(1);
    key_n[1] = 0; idle(1);
    key_n[1] = 1; idle(1);
    key_n[1] = 0;
    idle(5);
    rd(3'd0, d); chk("deb_edge6_pre", d, 32'h0);
    rd(3'd0, d); chk("deb_edge7_data", d, 32'h2);
    rd(3'd3, d); chk("deb_pending", d, 32'h2);

    // irq path
    settle();
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h2);
    key_n[1] = 0;
    idle(7);
    chk("irq_pend_cycle", 32'(bus.irq), 32'h0);
    idle(1);
    chk("irq_set", 32'(bus.irq), 32'h1);
    wr(3'd3, 32'h2);
    chk("irq_hold", 32'(bus.irq), 32'h1);
    idle(1);
    chk("irq_clear", 32'(bus.irq), 32'h0);

    // round robin
    settle();
    wr(3'd2, 32'hF);
    key_n = 4'b0010;
    idle(10);
    rd(3'd4, d); chk("rr_0", d, 32'h8000_0100);
    rd(3'd4, d); chk("rr_1", d, 32'h8000_0102);
    rd(3'd4, d); chk("rr_2", d, 32'h8000_0103);
    rd(3'd4, d); chk("rr_3", d, 32'h0000_0000);

    // set beats clear
    settle();
    key_n[0] = 0;
    idle(6);
    wr(3'd3, 32'h1);
    rd(3'd3, d); chk("set_over_clr", d, 32'h1);

    // release event
    wr(3'd3, 32'hF);
    wr(3'd1, 32'h3);
    key_n[2] = 0;
    idle(10);
    wr(3'd3, 32'hF);
    key_n[2] = 1;
    idle(10);
    rd(3'd4, d); chk("release_ev", d, 32'h8000_0002);

    // reset mid-debounce with a held key
    settle();
    rd(3'd1, d); chk("ctrl_rb", d, 32'h3);
    key_n[1] = 0;
    idle(3);
    reset_n = 0;
    #1;
    chk("rst_async_rd", bus.readdata, 32'h0);
    chk("rst_async_irq", 32'(bus.irq), 32'h0);
    idle(3);
    reset_n = 1;
    idle(5);
    rd(3'd0, d); chk("rst_edge6_pre", d, 32'h0);
    rd(3'd0, d); chk("rst_edge7_data", d, 32'h2);
    rd(3'd3, d); chk("rst_pending", d, 32'h2);

    // random traffic
    mon_en = 1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        key_n = W'($urandom);
        idle($urandom_range(0, 7));
      end else if (r < 6) begin
        rd(3'($urandom_range(0, 7)), d);
      end else if (r < 8) begin
        wr(3'($urandom_range(1, 3)),
           $urandom & 32'h0000_000F);
      end else begin
        idle($urandom_range(1, 4));
      end
    end
    mon_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
